lsu_align: RTL and testbench
============================

// Module: lsu_align
// PURPOSE
//  Load/store alignment unit between the CPU execute stage and the DataMemory data port.
//  Accepts one byte/half/word request, drives byte-lane masks, shifted store data and word addresses.
//  Returns the aligned, sign/zero-extended load result one pulse per request.
//  Holds the 1-cycle read latency of the sdp_bram read port.
// PARAMETERS
//  ADDR_W  32  request/memory byte-address width
//  DATA_W  32  data width; fixed at 32, four byte lanes
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   synchronous active-low reset
//  req_valid_i  in   1   request present
//  req_ready_o  out  1   unit can accept; high only in IDLE
//  req_we_i     in   1   1=store, 0=load
//  req_ctrl_i   in   4   [3]=sign [2]=word [1]=half [0]=byte
//  req_addr_i   in   32  byte address
//  req_wdata_i  in   32  store data, LSB-justified
//  rsp_valid_o  out  1   one-cycle completion pulse; no back-pressure
//  rsp_rdata_o  out  32  extended load data; 0 for stores and errors
//  rsp_err_o    out  1   illegal ctrl, or misaligned access when split is disabled
//  mem_wr_en_o  out  1   to DataMemory wr_en
//  mem_rd_en_o  out  1   to DataMemory rd_en
//  mem_ctrl_o   out  4   byte write mask to DataMemory ctrl
//  mem_addr_o   out  32  word-aligned byte address, [1:0]=0
//  mem_wdata_o  out  32  lane-shifted store data
//  mem_rdata_i  in   32  read word, valid the cycle after mem_rd_en_o
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//   - state=IDLE.
//   - All mem_* enables/masks, rsp_valid_o, rsp_err_o and rsp_rdata_o are 0.
//   - req_ready_o is 0 while rst_n=0.
//   - A reset mid-operation abandons the access; no rsp pulse; a pending second beat is dropped.
//  Accept and decode
//   - Accept at cycle T when req_valid_i & req_ready_o; request fields are registered.
//   - off = addr[1:0]; size = 1/2/4 from the one-hot ctrl[2:0].
//   - ctrl[2:0] zero or not one-hot -> rsp_valid_o + rsp_err_o at T+1; no memory access.
//  Lane mapping
//   - 8-bit mask = {4'b0, sizemask} << off, where sizemask = 0001/0011/1111.
//   - 64-bit data = {32'b0, wdata & sizemask-expanded} << 8*off.
//   - Beat0: mask[3:0], data[31:0], address addr & ~3.
//   - Beat1: mask[7:4], data[63:32], address (addr & ~3) + 4; wraps modulo 2^32.
//   - Misaligned means off + size > 4.
//  Aligned store
//   - mem_wr_en_o at T+1; rsp_valid_o at T+1; rdata=0.
//  Aligned load
//   - mem_rd_en_o at T+1 (mem_ctrl_o=0); capture mem_rdata_i at T+2.
//   - rsp_valid_o at T+2: (word >> 8*off) truncated to size; sign-extended if ctrl[3], else zero-extended.
//   - ctrl[3] is ignored for word loads.
//  States: IDLE -> BEAT0 -> [BEAT1] -> [RDWAIT] -> IDLE
//   - Return to IDLE on the edge that produces rsp_valid_o.
//   - Next accept is possible in the cycle after the rsp pulse.
//   - req_* is ignored outside IDLE.
// CONFIGURATION
//  LSU_MISALIGN_SPLIT_EN defined
//   - Misaligned half/word is split into two word beats in consecutive cycles (T+1, T+2).
//   - Store: rsp at T+2.
//   - Load: beat0 data is held; result = ({hi,lo} >> 8*off) extended; rsp at T+3.
//  LSU_MISALIGN_SPLIT_EN undefined
//   - Misaligned access -> rsp_valid_o + rsp_err_o at T+1; no mem enables; rdata=0.
// STRUCTURE
//  Shared package lsu_pkg
//   - State enum (IDLE, BEAT0, BEAT1, RDWAIT).
//   - CTRL_SIGN/WORD/HALF/BYTE bit indices.
//   - Function size_mask(ctrl) returning the 4-bit size mask.
//  Sub-module lsu_load_extend (combinational)
//   - Inputs: {hi,lo}, off, ctrl. Output: extended 32-bit result.
//  The FSM, beat registers and lane-shift logic stay in lsu_align.
// TESTING
//  - sb addr=0x103, wdata=0xAB -> T+1: wr_en=1, mask=1000, wdata=0xAB000000, addr=0x100; rsp T+1 err=0.
//  - lb signed addr=0x102, mem word 0x00F50000 -> rd at T+1; rsp T+2 rdata=0xFFFFFFF5. lbu same -> 0x000000F5.
//  - ctrl=4'b0110 -> rsp T+1 err=1; wr_en and rd_en stay 0 throughout.
//  - lw addr=0x0FE, mem[0x0FC]=0x44332211, mem[0x100]=0x88776655:
//    split -> rd 0x0FC at T+1, rd 0x100 at T+2, rsp T+3 rdata=0x66554433; no split -> err at T+1.
//  - sh addr=0x0FF, wdata=0xBEEF, split:
//    beat0 mask=1000 data=0xEF000000 addr=0x0FC; beat1 mask=0001 data=0x000000BE addr=0x100.
//  - rst_n=0 at T+1 of a load -> no rsp_valid_o; req_ready_o=1 the cycle after rst_n returns to 1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store alignment unit.
//   lsu_state_e : FSM states (IDLE, BEAT0, BEAT1, RDWAIT)
//   CTRL_*      : bit indices of the request ctrl field
//   size_mask() : one-hot size select -> byte-lane mask before shifting;
//                 returns 0 for a zero or non-one-hot select (illegal request)
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BEAT0  = 2'd1,
    BEAT1  = 2'd2,
    RDWAIT = 2'd3
  } lsu_state_e;

  localparam int CTRL_SIGN = 3;
  localparam int CTRL_WORD = 2;
  localparam int CTRL_HALF = 1;
  localparam int CTRL_BYTE = 0;

  // size_sel is ctrl[2:0]; only one-hot values are legal.
  function automatic logic [3:0] size_mask(input logic [2:0] size_sel);
    case (size_sel)
      3'b001:  size_mask = 4'b0001;
      3'b010:  size_mask = 4'b0011;
      3'b100:  size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align_load_extend.sv
// Combinational load-result extraction.
//   data_i   : {hi,lo} memory words (hi is 0 for a single-beat load)
//   off_i    : byte offset of the request address
//   ctrl_i   : request ctrl ([3]=sign [2]=word [1]=half [0]=byte)
//   result_o : selected bytes, sign- or zero-extended to 32 bits
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [63:0] data_i,
  input  logic [1:0]  off_i,
  input  logic [3:0]  ctrl_i,
  output logic [31:0] result_o
);

  logic [63:0] shifted;
  logic [31:0] word;
  logic        unused_hi;

  assign shifted   = data_i >> {off_i, 3'b000};
  assign word      = shifted[31:0];
  assign unused_hi = ^shifted[63:32];

  // Word loads pass through untouched, so the sign bit has no effect there.
  always_comb begin
    result_o = word;
    if (ctrl_i[CTRL_BYTE]) begin
      result_o = {{24{ctrl_i[CTRL_SIGN] & word[7]}}, word[7:0]};
    end else if (ctrl_i[CTRL_HALF]) begin
      result_o = {{16{ctrl_i[CTRL_SIGN] & word[15]}}, word[15:0]};
    end
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit between the execute stage and a 1-cycle-latency
// word-wide data memory port.
//   clk, rst_n        : clock, synchronous active-low reset
//   req_*             : one byte/half/word request, accepted in IDLE
//   rsp_*             : one-cycle completion pulse with extended load data / error
//   mem_*             : word-addressed memory port with byte write mask
// Build option: define LSU_MISALIGN_SPLIT_EN to split accesses that cross a
// word boundary into two consecutive word beats; otherwise they complete with
// an error and no memory access.
// Handshake: a request is taken on a rising edge where req_valid_i and
// req_ready_o are both high; req_ready_o is high only in IDLE (and never under
// reset); the response has no back-pressure and the next request can be taken
// in the cycle after the rsp_valid_o pulse.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [3:0]        req_ctrl_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              mem_wr_en_o,
  output logic              mem_rd_en_o,
  output logic [3:0]        mem_ctrl_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [3:0]        ctrl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] lo_q;

  logic              accept;
  logic [1:0]        off;
  logic [3:0]        smask;
  logic              illegal;
  logic [7:0]        mask8;
  logic              misaligned;
  logic [31:0]       wmask;
  logic [63:0]       data64;
  logic [ADDR_W-1:0] word_addr;
  logic [63:0]       ext_in;
  logic [31:0]       ext_rdata;

  assign accept     = req_valid_i & req_ready_o;
  assign off        = addr_q[1:0];
  assign smask      = size_mask(ctrl_q[2:0]);
  assign illegal    = (smask == 4'b0000);
  // Lanes 7:4 belong to the following word; any bit there means a crossing.
  assign mask8      = {4'b0000, smask} << off;
  assign misaligned = |mask8[7:4];
  assign wmask      = {{8{smask[3]}}, {8{smask[2]}}, {8{smask[1]}}, {8{smask[0]}}};
  assign data64     = {32'h0, wdata_q & wmask} << {off, 3'b000};
  assign word_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  // A crossing load reaches RDWAIT with its low word held in lo_q and its high
  // word on the read port; a single-beat load only has the read port word.
  assign ext_in     = misaligned ? {mem_rdata_i, lo_q} : {32'h0, mem_rdata_i};

  lsu_load_extend u_extend (
    .data_i   (ext_in),
    .off_i    (off),
    .ctrl_i   (ctrl_q),
    .result_o (ext_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      ctrl_q  <= 4'h0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= req_we_i;
        ctrl_q  <= req_ctrl_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
      end
      // The first word of a split load arrives while the second is being read.
      if (state_q == BEAT1 && !we_q) begin
        lo_q <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    mem_wr_en_o = 1'b0;
    mem_rd_en_o = 1'b0;
    mem_ctrl_o  = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    // Outputs are forced quiet for the whole time reset is asserted.
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          req_ready_o = 1'b1;
          if (req_valid_i) state_d = BEAT0;
        end
        BEAT0: begin
          if (illegal || (misaligned && !SPLIT_EN)) begin
            rsp_valid_o = 1'b1;
            rsp_err_o   = 1'b1;
            state_d     = IDLE;
          end else begin
            mem_addr_o = word_addr;
            if (we_q) begin
              mem_wr_en_o = 1'b1;
              mem_ctrl_o  = mask8[3:0];
              mem_wdata_o = data64[31:0];
              if (misaligned) begin
                state_d = BEAT1;
              end else begin
                rsp_valid_o = 1'b1;
                state_d     = IDLE;
              end
            end else begin
              mem_rd_en_o = 1'b1;
              state_d     = misaligned ? BEAT1 : RDWAIT;
            end
          end
        end
        BEAT1: begin
          mem_addr_o = word_addr + ADDR_W'(4);
          if (we_q) begin
            mem_wr_en_o = 1'b1;
            mem_ctrl_o  = mask8[7:4];
            mem_wdata_o = data64[63:32];
            rsp_valid_o = 1'b1;
            state_d     = IDLE;
          end else begin
            mem_rd_en_o = 1'b1;
            state_d     = RDWAIT;
          end
        end
        RDWAIT: begin
          rsp_valid_o = 1'b1;
          rsp_rdata_o = ext_rdata;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Bench for lsu_align: directed vector table, randomized requests against a
// byte-level reference model, and reset corner sequences.
module tb_lsu_align;

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_we_i = 1'b0;
  logic [3:0]  req_ctrl_i = 4'h0;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        req_ready_o, rsp_valid_o, rsp_err_o, mem_wr_en_o, mem_rd_en_o;
  logic [31:0] rsp_rdata_o, mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_ctrl_o;

  always #5 clk = ~clk;

  lsu_align dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_we_i    (req_we_i),
    .req_ctrl_i  (req_ctrl_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .mem_wr_en_o (mem_wr_en_o),
    .mem_rd_en_o (mem_rd_en_o),
    .mem_ctrl_o  (mem_ctrl_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i)
  );

  // ---------------- byte memory model ----------------
  logic [7:0] mem_b [logic [31:0]];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem_b.exists(a)) return mem_b[a];
    return 8'(a * 32'd37 + 32'd11);
  endfunction

  function automatic logic [31:0] rd_word(input logic [31:0] wa);
    return {rd_byte(wa + 32'd3), rd_byte(wa + 32'd2), rd_byte(wa + 32'd1), rd_byte(wa)};
  endfunction

  task automatic set_word(input logic [31:0] wa, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem_b[wa + 32'(k)] = w[8*k +: 8];
  endtask

  // Read port: data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (mem_rd_en_o) mem_rdata_i <= rd_word(mem_addr_o);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [68:0] exp_q[$];   // expected memory beats {wr, addr, mask, data}
  logic [68:0] act_q[$];   // observed memory beats

  function automatic logic [68:0] mk_beat(input bit wr, input logic [31:0] a,
                                          input logic [3:0] m, input logic [31:0] d);
    return {wr, a, m, d};
  endfunction

  task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cmp_beats(input string tag);
    chk({tag, "_nbeats"}, 69'(act_q.size()), 69'(exp_q.size()));
    for (int b = 0; b < exp_q.size() && b < act_q.size(); b++)
      chk($sformatf("%s_beat%0d", tag, b), act_q[b], exp_q[b]);
  endtask

  // Reference: walk the request byte by byte, grouping bytes into words.
  task automatic model(input bit we, input logic [3:0] ctrl, input logic [31:0] addr,
                       input logic [31:0] wdata, output int lat, output bit err,
                       output logic [31:0] rdata);
    int size, nb;
    bit mis;
    logic [31:0] a, wa, val;
    logic [31:0] baddr [2];
    logic [3:0]  bmask [2];
    logic [31:0] bdata [2];
    exp_q.delete();
    case (ctrl[2:0])
      3'b001:  size = 1;
      3'b010:  size = 2;
      3'b100:  size = 4;
      default: size = 0;
    endcase
    mis = (int'(addr[1:0]) + size) > 4;
    lat = 1; err = 1'b0; rdata = 32'h0;
    if (size == 0 || (mis && !SPLIT)) begin
      err = 1'b1;
      return;
    end
    nb = 0; val = 32'h0;
    for (int i = 0; i < size; i++) begin
      a  = addr + 32'(i);
      wa = {a[31:2], 2'b00};
      if (nb == 0 || baddr[nb-1] != wa) begin
        baddr[nb] = wa; bmask[nb] = 4'h0; bdata[nb] = 32'h0; nb++;
      end
      bmask[nb-1][a[1:0]] = 1'b1;
      bdata[nb-1][8*a[1:0] +: 8] = wdata[8*i +: 8];
      val[8*i +: 8] = rd_byte(a);
    end
    for (int b = 0; b < nb; b++)
      exp_q.push_back(we ? mk_beat(1'b1, baddr[b], bmask[b], bdata[b])
                         : mk_beat(1'b0, baddr[b], 4'h0, 32'h0));
    if (we) begin
      lat = nb;
    end else begin
      lat = nb + 1;
      case (size)
        1:       rdata = ctrl[3] ? {{24{val[7]}}, val[7:0]} : {24'h0, val[7:0]};
        2:       rdata = ctrl[3] ? {{16{val[15]}}, val[15:0]} : {16'h0, val[15:0]};
        default: rdata = val;
      endcase
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge; returns at the falling edge of the response cycle.
  task automatic run_req(input bit we, input logic [3:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, input string tag, output int lat,
                         output bit err, output logic [31:0] rdata);
    int n;
    bit busy_ready;
    act_q.delete();
    lat = 0; err = 1'b0; rdata = 32'h0; busy_ready = 1'b0;
    req_valid_i = 1'b1; req_we_i = we; req_ctrl_i = ctrl;
    req_addr_i = addr; req_wdata_i = wdata;
    n = 0;
    while (!req_ready_o && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_accept: req_ready_o never rose", tag);
      req_valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    req_addr_i  = $urandom;
    req_wdata_i = $urandom;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (mem_wr_en_o) begin
        act_q.push_back(mk_beat(1'b1, mem_addr_o, mem_ctrl_o, mem_wdata_o));
        for (int k = 0; k < 4; k++)
          if (mem_ctrl_o[k]) mem_b[mem_addr_o + 32'(k)] = mem_wdata_o[8*k +: 8];
      end
      if (mem_rd_en_o) act_q.push_back(mk_beat(1'b0, mem_addr_o, 4'h0, 32'h0));
      if (req_ready_o) busy_ready = 1'b1;
      if (rsp_valid_o) begin
        lat = c; err = rsp_err_o; rdata = rsp_rdata_o;
        break;
      end
    end
    chk({tag, "_ready_busy"}, 69'(busy_ready), 69'(0));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          we;
    logic [3:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          pre;
    logic [31:0] pre_addr;
    logic [31:0] pre_word;
    int          lat;
    bit          err;
    logic [31:0] rdata;
    bit          chk_b0;
    logic [68:0] b0;
  } vec_t;

  vec_t vt [12];

  initial begin
    int lat, m_lat;
    bit err, m_err, seen;
    logic [31:0] rdata, m_rdata, addr, wdata;
    logic [3:0] ctrl;
    bit we;
    string tag;

    vt[0]  = '{1'b1, 4'b0001, 32'h103, 32'hAB, 1'b0, 32'h0, 32'h0, 1, 1'b0, 32'h0,
               1'b1, mk_beat(1'b1, 32'h100, 4'b1000, 32'hAB000000)};
    vt[1]  = '{1'b0, 4'b1001, 32'h102, 32'h0, 1'b1, 32'h100, 32'h00F50000, 2, 1'b0,
               32'hFFFFFFF5, 1'b1, mk_beat(1'b0, 32'h100, 4'h0, 32'h0)};
    vt[2]  = '{1'b0, 4'b0001, 32'h102, 32'h0, 1'b0, 32'h0, 32'h0, 2, 1'b0,
               32'h000000F5, 1'b1, mk_beat(1'b0, 32'h100, 4'h0, 32'h0)};
    vt[3]  = '{1'b0, 4'b0110, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 1, 1'b1, 32'h0,
               1'b0, 69'h0};
    vt[4]  = '{1'b1, 4'b0000, 32'h104, 32'hFFFF, 1'b0, 32'h0, 32'h0, 1, 1'b1, 32'h0,
               1'b0, 69'h0};
    vt[5]  = '{1'b0, 4'b0100, 32'h0FE, 32'h0, 1'b1, 32'h100, 32'h88776655,
               SPLIT ? 3 : 1, !SPLIT, SPLIT ? 32'h66554433 : 32'h0,
               SPLIT, mk_beat(1'b0, 32'h0FC, 4'h0, 32'h0)};
    vt[6]  = '{1'b1, 4'b0010, 32'h0FF, 32'hBEEF, 1'b0, 32'h0, 32'h0,
               SPLIT ? 2 : 1, !SPLIT, 32'h0,
               SPLIT, mk_beat(1'b1, 32'h0FC, 4'b1000, 32'hEF000000)};
    vt[7]  = '{1'b1, 4'b0100, 32'h200, 32'h12345678, 1'b0, 32'h0, 32'h0, 1, 1'b0, 32'h0,
               1'b1, mk_beat(1'b1, 32'h200, 4'b1111, 32'h12345678)};
    vt[8]  = '{1'b0, 4'b1010, 32'h102, 32'h0, 1'b1, 32'h100, 32'h80010000, 2, 1'b0,
               32'hFFFF8001, 1'b1, mk_beat(1'b0, 32'h100, 4'h0, 32'h0)};
    vt[9]  = '{1'b1, 4'b0010, 32'hFFFFFFFF, 32'h1234, 1'b0, 32'h0, 32'h0,
               SPLIT ? 2 : 1, !SPLIT, 32'h0,
               SPLIT, mk_beat(1'b1, 32'hFFFFFFFC, 4'b1000, 32'h34000000)};
    vt[10] = '{1'b0, 4'b1100, 32'h100, 32'h0, 1'b0, 32'h0, 32'h0, 2, 1'b0,
               32'h80010000, 1'b1, mk_beat(1'b0, 32'h100, 4'h0, 32'h0)};
    vt[11] = '{1'b0, 4'b0010, 32'h101, 32'h0, 1'b0, 32'h0, 32'h0, 2, 1'b0,
               32'h00000100, 1'b1, mk_beat(1'b0, 32'h100, 4'h0, 32'h0)};

    // Reset: outputs quiet and not ready, even with a request pending.
    req_valid_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        69'({req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o,
             mem_wr_en_o, mem_rd_en_o, mem_ctrl_o}), 69'(0));
    req_valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 69'(req_ready_o), 69'(1));

    set_word(32'h0FC, 32'h44332211);

    for (int i = 0; i < 12; i++) begin
      tag = $sformatf("vec%0d", i);
      if (vt[i].pre) set_word(vt[i].pre_addr, vt[i].pre_word);
      model(vt[i].we, vt[i].ctrl, vt[i].addr, vt[i].wdata, m_lat, m_err, m_rdata);
      run_req(vt[i].we, vt[i].ctrl, vt[i].addr, vt[i].wdata, tag, lat, err, rdata);
      chk({tag, "_lat"}, 69'(lat), 69'(vt[i].lat));
      chk({tag, "_err"}, 69'(err), 69'(vt[i].err));
      chk({tag, "_rdata"}, 69'(rdata), 69'(vt[i].rdata));
      if (vt[i].chk_b0) chk({tag, "_b0"}, act_q.size() > 0 ? act_q[0] : 69'h0, vt[i].b0);
      cmp_beats(tag);
    end

    // Randomized requests against the reference model.
    for (int i = 0; i < 200; i++) begin
      tag = $sformatf("rnd%0d", i);
      we  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      else                           addr = 32'($urandom_range(0, 255));
      wdata = $urandom;
      if ($urandom_range(0, 9) == 0) begin
        ctrl = 4'($urandom_range(0, 15));
      end else begin
        ctrl = 4'b0001 << $urandom_range(0, 2);
        ctrl[3] = 1'($urandom_range(0, 1));
      end
      model(we, ctrl, addr, wdata, m_lat, m_err, m_rdata);
      run_req(we, ctrl, addr, wdata, tag, lat, err, rdata);
      chk({tag, "_lat"}, 69'(lat), 69'(m_lat));
      chk({tag, "_err"}, 69'(err), 69'(m_err));
      chk({tag, "_rdata"}, 69'(rdata), 69'(m_rdata));
      cmp_beats(tag);
    end

    // Ready again in the cycle after the last response pulse.
    @(negedge clk);
    chk("ready_after_rsp", 69'(req_ready_o), 69'(1));

    // Reset during the read beat of a load: no response, ready after release.
    req_valid_i = 1'b1; req_we_i = 1'b0; req_ctrl_i = 4'b0100;
    req_addr_i = 32'h200; req_wdata_i = 32'h0;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    @(negedge clk);
    chk("rst_mid_rd_en", 69'(mem_rd_en_o), 69'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_mid_rd_gated", 69'(mem_rd_en_o), 69'(0));
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid_o) seen = 1'b1;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (rsp_valid_o) seen = 1'b1;
    chk("rst_mid_ready", 69'(req_ready_o), 69'(1));
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid_o) seen = 1'b1;
    end
    chk("rst_mid_no_rsp", 69'(seen), 69'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
